// File: rtl/wt_inv_sequencer.sv
// Invalidation sequencer for the write-through L1s: queues line invalidations,
// broadcasts each to I$ and D$, and reports completion once both have acknowledged.
module wt_inv_sequencer #(
    parameter int PLEN      = 56,
    parameter int FifoDepth = 4,
    parameter int CntWidth  = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    // Request handshake: an invalidation transfers on a rising edge where
    // inv_req_i & inv_gnt_o; inv_gnt_o never depends on inv_req_i.
    input  logic                inv_req_i,
    input  logic [PLEN-1:0]     inv_addr_i,
    output logic                inv_gnt_o,
    output logic                inv_done_o,
    output logic [PLEN-1:0]     inv_done_addr_o,
    output logic                icache_inv_req_o,
    output logic [PLEN-1:0]     icache_inv_addr_o,
    input  logic                icache_inv_ack_i,
    output logic                dcache_inv_req_o,
    output logic [PLEN-1:0]     dcache_inv_addr_o,
    input  logic                dcache_inv_ack_i,
    output logic                busy_o,
    output logic [CntWidth-1:0] inv_cnt_o,
    output logic [1:0]          dbg_state_o
);

    localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int OccW = $clog2(FifoDepth + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [PLEN-1:0]     mem_q [FifoDepth];
    logic [PtrW-1:0]     wptr_q, wptr_d;
    logic [PtrW-1:0]     rptr_q, rptr_d;
    logic [OccW-1:0]     occ_q, occ_d;
    logic                ic_pend_q, ic_pend_d;
    logic                dc_pend_q, dc_pend_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;

    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic [PLEN-1:0] head;

    assign full  = (occ_q == OccW'(FifoDepth));
    assign empty = (occ_q == '0);
    assign push  = inv_req_i & ~full;
    assign head  = mem_q[rptr_q];

    // FIFO bookkeeping; pointers wrap naturally since the depth is a power of two.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        occ_d  = occ_q;
        if (push) begin
            wptr_d = wptr_q + PtrW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + OccW'(1);
            2'b01:   occ_d = occ_q - OccW'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Sequencing FSM; acks only matter in ISSUE and only while their pend flag is set.
    always_comb begin
        state_d   = state_q;
        ic_pend_d = ic_pend_q;
        dc_pend_d = dc_pend_q;
        cnt_d     = cnt_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d   = ISSUE;
                    ic_pend_d = 1'b1;
                    dc_pend_d = 1'b1;
                end
            end
            ISSUE: begin
                ic_pend_d = ic_pend_q & ~icache_inv_ack_i;
                dc_pend_d = dc_pend_q & ~dcache_inv_ack_i;
                if (!ic_pend_d && !dc_pend_d) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                pop   = 1'b1;
                cnt_d = cnt_q + CntWidth'(1);
                // Only entries already queued count; a same-cycle push goes through IDLE.
                if (occ_q > OccW'(1)) begin
                    state_d   = ISSUE;
                    ic_pend_d = 1'b1;
                    dc_pend_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                ic_pend_d = 1'b0;
                dc_pend_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            wptr_q    <= '0;
            rptr_q    <= '0;
            occ_q     <= '0;
            ic_pend_q <= 1'b0;
            dc_pend_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            occ_q     <= occ_d;
            ic_pend_q <= ic_pend_d;
            dc_pend_q <= dc_pend_d;
            cnt_q     <= cnt_d;
        end
    end

    // Storage is cleared on reset so the head, and thus every address output, reads 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FifoDepth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wptr_q] <= inv_addr_i;
        end
    end

    assign inv_gnt_o         = ~full;
    assign inv_done_o        = (state_q == DONE);
    assign inv_done_addr_o   = head;
    assign icache_inv_req_o  = (state_q == ISSUE) & ic_pend_q;
    assign dcache_inv_req_o  = (state_q == ISSUE) & dc_pend_q;
    assign icache_inv_addr_o = head;
    assign dcache_inv_addr_o = head;
    assign busy_o            = ~empty | (state_q != IDLE);
    assign inv_cnt_o         = cnt_q;
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_wt_inv_sequencer.sv
// Bench for wt_inv_sequencer: directed scenarios plus random traffic, with a
// queue-based reference model checked by an independent monitor.
module tb_wt_inv_sequencer;

    localparam int PLEN  = 56;
    localparam int DEPTH = 4;
    localparam int CW    = 16;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            inv_req_i;
    logic [PLEN-1:0] inv_addr_i;
    logic            inv_gnt_o;
    logic            inv_done_o;
    logic [PLEN-1:0] inv_done_addr_o;
    logic            icache_inv_req_o;
    logic [PLEN-1:0] icache_inv_addr_o;
    logic            icache_inv_ack_i;
    logic            dcache_inv_req_o;
    logic [PLEN-1:0] dcache_inv_addr_o;
    logic            dcache_inv_ack_i;
    logic            busy_o;
    logic [CW-1:0]   inv_cnt_o;
    logic [1:0]      dbg_state;

    wt_inv_sequencer #(.PLEN(PLEN), .FifoDepth(DEPTH), .CntWidth(CW)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .inv_req_i         (inv_req_i),
        .inv_addr_i        (inv_addr_i),
        .inv_gnt_o         (inv_gnt_o),
        .inv_done_o        (inv_done_o),
        .inv_done_addr_o   (inv_done_addr_o),
        .icache_inv_req_o  (icache_inv_req_o),
        .icache_inv_addr_o (icache_inv_addr_o),
        .icache_inv_ack_i  (icache_inv_ack_i),
        .dcache_inv_req_o  (dcache_inv_req_o),
        .dcache_inv_addr_o (dcache_inv_addr_o),
        .dcache_inv_ack_i  (dcache_inv_ack_i),
        .busy_o            (busy_o),
        .inv_cnt_o         (inv_cnt_o),
        .dbg_state_o       (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [PLEN-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    logic ic_drop_due = 1'b0;
    logic dc_drop_due = 1'b0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, req);
    endfunction

    // ---------------- driver tasks ----------------
    // Advance one cycle; an accepted request enters the model at the edge that takes it.
    task automatic step();
        @(posedge clk);
        if (rst_n && inv_req_i && inv_gnt_o) exp_q.push_back(inv_addr_i);
        #1;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (busy_o && n < max_cycles) begin
            step();
            n++;
        end
        check("drain_timeout", 64'(busy_o), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"}, 64'(inv_gnt_o), 64'd1);
        check({tag, "_done"}, 64'(inv_done_o), 64'd0);
        check({tag, "_icreq"}, 64'(icache_inv_req_o), 64'd0);
        check({tag, "_dcreq"}, 64'(dcache_inv_req_o), 64'd0);
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
        check({tag, "_cnt"}, 64'(inv_cnt_o), 64'd0);
        check({tag, "_icaddr"}, 64'(icache_inv_addr_o), 64'd0);
        check({tag, "_dcaddr"}, 64'(dcache_inv_addr_o), 64'd0);
        check({tag, "_doneaddr"}, 64'(inv_done_addr_o), 64'd0);
        check({tag, "_state"}, 64'(dbg_state), 64'd0);
    endtask

    // ---------------- monitor ----------------
    // Model: the queue holds every accepted, not yet completed address in push order.
    always @(negedge clk) begin
        if (!rst_n) begin
            done_cnt    = 0;
            ic_drop_due = 1'b0;
            dc_drop_due = 1'b0;
        end else begin
            check("mon_gnt", 64'(inv_gnt_o), 64'(exp_q.size() < DEPTH));
            check("mon_busy", 64'(busy_o), 64'(exp_q.size() != 0));
            if (ic_drop_due) check("mon_ic_drop", 64'(icache_inv_req_o), 64'd0);
            if (dc_drop_due) check("mon_dc_drop", 64'(dcache_inv_req_o), 64'd0);
            if (icache_inv_req_o) begin
                check("mon_ic_req_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) check("mon_ic_addr", 64'(icache_inv_addr_o), 64'(exp_q[0]));
            end
            if (dcache_inv_req_o) begin
                check("mon_dc_req_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) check("mon_dc_addr", 64'(dcache_inv_addr_o), 64'(exp_q[0]));
            end
            if (inv_done_o) begin
                check("mon_done_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    check("mon_done_addr", 64'(inv_done_addr_o), 64'(exp_q[0]));
                    check("mon_cnt", 64'(inv_cnt_o), 64'(CW'(done_cnt)));
                    void'(exp_q.pop_front());
                    done_cnt++;
                end
            end
            ic_drop_due = icache_inv_req_o && icache_inv_ack_i;
            dc_drop_due = dcache_inv_req_o && dcache_inv_ack_i;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int d0;
        logic [PLEN-1:0] base;
        inv_req_i        = 1'b0;
        inv_addr_i       = '0;
        icache_inv_ack_i = 1'b0;
        dcache_inv_ack_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        step();

        // Single invalidation at minimum latency.
        icache_inv_ack_i = 1'b1;
        dcache_inv_ack_i = 1'b1;
        inv_req_i  = 1'b1;
        inv_addr_i = PLEN'(64'h8000_1040);
        check("t1_gnt", 64'(inv_gnt_o), 64'd1);
        step(); inv_req_i = 1'b0;
        check("t1_icreq_t1", 64'(icache_inv_req_o), 64'd0);
        step();
        check("t1_icreq_t2", 64'(icache_inv_req_o), 64'd1);
        check("t1_dcreq_t2", 64'(dcache_inv_req_o), 64'd1);
        check("t1_icaddr", 64'(icache_inv_addr_o), 64'h8000_1040);
        check("t1_dcaddr", 64'(dcache_inv_addr_o), 64'h8000_1040);
        step();
        check("t1_icreq_t3", 64'(icache_inv_req_o), 64'd0);
        check("t1_dcreq_t3", 64'(dcache_inv_req_o), 64'd0);
        check("t1_done_t3", 64'(inv_done_o), 64'd1);
        check("t1_doneaddr", 64'(inv_done_addr_o), 64'h8000_1040);
        step();
        check("t1_done_t4", 64'(inv_done_o), 64'd0);
        check("t1_cnt", 64'(inv_cnt_o), 64'd1);
        check("t1_busy", 64'(busy_o), 64'd0);

        // Skewed acks: I$ one cycle after the request rises, D$ five cycles after.
        icache_inv_ack_i = 1'b0;
        dcache_inv_ack_i = 1'b0;
        d0 = done_cnt;
        inv_req_i  = 1'b1;
        inv_addr_i = PLEN'(64'h0012_3456_7880);
        step(); inv_req_i = 1'b0;
        step();
        check("t2_icreq_rise", 64'(icache_inv_req_o), 64'd1);
        check("t2_dcreq_rise", 64'(dcache_inv_req_o), 64'd1);
        step(); icache_inv_ack_i = 1'b1;
        check("t2_icreq_ack", 64'(icache_inv_req_o), 64'd1);
        step(); icache_inv_ack_i = 1'b0;
        check("t2_icreq_drop", 64'(icache_inv_req_o), 64'd0);
        check("t2_dcreq_hold", 64'(dcache_inv_req_o), 64'd1);
        step(); step();
        check("t2_dcreq_hold2", 64'(dcache_inv_req_o), 64'd1);
        check("t2_no_early_done", 64'(inv_done_o), 64'd0);
        step(); dcache_inv_ack_i = 1'b1;
        check("t2_done_not_yet", 64'(inv_done_o), 64'd0);
        step(); dcache_inv_ack_i = 1'b0;
        check("t2_done", 64'(inv_done_o), 64'd1);
        check("t2_dcreq_drop", 64'(dcache_inv_req_o), 64'd0);
        step();
        check("t2_done_pulse", 64'(inv_done_o), 64'd0);
        check("t2_one_done", 64'(done_cnt - d0), 64'd1);

        // FIFO full: four pushes fill it, the fifth waits for the first completion.
        d0   = done_cnt;
        base = PLEN'(64'h00AB_0000_1000);
        for (int i = 0; i < 4; i++) begin
            inv_req_i  = 1'b1;
            inv_addr_i = base + PLEN'(i * 64);
            check("t3_gnt_fill", 64'(inv_gnt_o), 64'd1);
            step();
        end
        inv_addr_i = base + PLEN'(4 * 64);
        check("t3_gnt_full", 64'(inv_gnt_o), 64'd0);
        step();
        check("t3_gnt_full2", 64'(inv_gnt_o), 64'd0);
        step();
        icache_inv_ack_i = 1'b1;
        dcache_inv_ack_i = 1'b1;
        check("t3_gnt_full3", 64'(inv_gnt_o), 64'd0);
        step();
        icache_inv_ack_i = 1'b0;
        dcache_inv_ack_i = 1'b0;
        check("t3_first_done", 64'(inv_done_o), 64'd1);
        check("t3_first_addr", 64'(inv_done_addr_o), 64'(base));
        check("t3_gnt_in_done", 64'(inv_gnt_o), 64'd0);
        step();
        check("t3_gnt_back", 64'(inv_gnt_o), 64'd1);
        step(); inv_req_i = 1'b0;
        icache_inv_ack_i = 1'b1;
        dcache_inv_ack_i = 1'b1;
        wait_idle(60);
        check("t3_done_count", 64'(done_cnt - d0), 64'd5);

        // Spurious acks while idle, then a repeated D$ ack after its flag cleared.
        d0 = done_cnt;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_idle_busy", 64'(busy_o), 64'd0);
            check("t4_idle_icreq", 64'(icache_inv_req_o), 64'd0);
            check("t4_idle_done", 64'(inv_done_o), 64'd0);
        end
        check("t4_idle_cnt", 64'(inv_cnt_o), 64'(CW'(done_cnt)));
        icache_inv_ack_i = 1'b0;
        inv_req_i  = 1'b1;
        inv_addr_i = PLEN'(64'h00CC_0000_2040);
        step(); inv_req_i = 1'b0;
        step();
        check("t4_both_req", 64'(icache_inv_req_o & dcache_inv_req_o), 64'd1);
        for (int i = 0; i < 2; i++) begin
            step();
            check("t4_ic_hold", 64'(icache_inv_req_o), 64'd1);
            check("t4_dc_low", 64'(dcache_inv_req_o), 64'd0);
            check("t4_no_done", 64'(inv_done_o), 64'd0);
        end
        icache_inv_ack_i = 1'b1;
        step();
        check("t4_done", 64'(inv_done_o), 64'd1);
        step();
        check("t4_done_pulse", 64'(inv_done_o), 64'd0);
        check("t4_one_done", 64'(done_cnt - d0), 64'd1);
        check("t4_cnt", 64'(inv_cnt_o), 64'(CW'(done_cnt)));

        // Push in the DONE cycle with two entries queued.
        d0 = done_cnt;
        icache_inv_ack_i = 1'b0;
        dcache_inv_ack_i = 1'b0;
        base = PLEN'(64'h00DD_0000_0000);
        inv_req_i = 1'b1; inv_addr_i = base;
        step(); inv_addr_i = base + PLEN'(64);
        step(); inv_req_i = 1'b0;
        icache_inv_ack_i = 1'b1;
        dcache_inv_ack_i = 1'b1;
        check("t5_issue_a", 64'(icache_inv_addr_o), 64'(base));
        step();
        icache_inv_ack_i = 1'b0;
        dcache_inv_ack_i = 1'b0;
        check("t5_done_a", 64'(inv_done_o), 64'd1);
        inv_req_i = 1'b1; inv_addr_i = base + PLEN'(128);
        check("t5_gnt_in_done", 64'(inv_gnt_o), 64'd1);
        step();
        check("t5_issue_next", 64'(icache_inv_req_o & dcache_inv_req_o), 64'd1);
        check("t5_issue_b", 64'(icache_inv_addr_o), 64'(base + PLEN'(64)));
        inv_addr_i = base + PLEN'(192);
        check("t5_gnt_occ2", 64'(inv_gnt_o), 64'd1);
        step(); inv_addr_i = base + PLEN'(256);
        check("t5_gnt_occ3", 64'(inv_gnt_o), 64'd1);
        step(); inv_req_i = 1'b0;
        check("t5_gnt_occ4", 64'(inv_gnt_o), 64'd0);
        icache_inv_ack_i = 1'b1;
        dcache_inv_ack_i = 1'b1;
        wait_idle(60);
        check("t5_done_count", 64'(done_cnt - d0), 64'd5);

        // Reset during ISSUE with three entries pending.
        icache_inv_ack_i = 1'b0;
        dcache_inv_ack_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            inv_req_i  = 1'b1;
            inv_addr_i = PLEN'(64'h00EE_0000_0000) + PLEN'(i * 64);
            step();
        end
        inv_req_i = 1'b0;
        check("t6_in_issue", 64'(icache_inv_req_o), 64'd1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("t6_rst");
        step(); step();
        rst_n = 1'b1;
        icache_inv_ack_i = 1'b1;
        dcache_inv_ack_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("t6_no_req", 64'(icache_inv_req_o | dcache_inv_req_o), 64'd0);
            check("t6_no_done", 64'(inv_done_o), 64'd0);
            check("t6_cnt", 64'(inv_cnt_o), 64'd0);
        end

        // Random traffic with random ack timing.
        for (int i = 0; i < 600; i++) begin
            inv_req_i        = ($urandom_range(0, 2) != 0);
            inv_addr_i       = PLEN'({$urandom(), $urandom()});
            icache_inv_ack_i = ($urandom_range(0, 3) == 0);
            dcache_inv_ack_i = ($urandom_range(0, 2) == 0);
            step();
        end
        inv_req_i        = 1'b0;
        icache_inv_ack_i = 1'b1;
        dcache_inv_ack_i = 1'b1;
        wait_idle(100);
        step();
        check("final_cnt", 64'(inv_cnt_o), 64'(CW'(done_cnt)));
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        check("final_state_idle", 64'(dbg_state), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard time limit in case a wait escapes its bound.
    initial begin
        #500000;
        $display("FAIL global_timeout: actual running, required finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wt_inv_sequencer.md
# wt_inv_sequencer

Sequences cache-line invalidation requests from the coherent memory side into the write-through L1 caches. Buffers incoming invalidations in a small FIFO, broadcasts each to both I$ and D$, collects both acknowledges independently, then signals completion. Sits between the memory adapter's snoop/invalidate output and the `mem_inv_*` ports of the instruction and data caches in the WT cache subsystem.

## Interface
Parameters:
- `PLEN`, default 56: physical address width (matches `riscv::PLEN`).
- `FifoDepth`, default 4: pending-invalidation FIFO entries; power of two, ≥2.
- `CntWidth`, default 16: width of the completion counter.

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `inv_req_i`  in  1  invalidation request from the adapter.
- `inv_addr_i`  in  PLEN  physical address of the line to invalidate.
- `inv_gnt_o`  out  1  request accepted this cycle when `inv_req_i & inv_gnt_o`.
- `inv_done_o`  out  1  one-cycle pulse: head invalidation acknowledged by both caches.
- `inv_done_addr_o`  out  PLEN  address of the completed invalidation; valid with `inv_done_o`.
- `icache_inv_req_o`  out  1  invalidate request to I$.
- `icache_inv_addr_o`  out  PLEN  address to I$.
- `icache_inv_ack_i`  in  1  I$ acknowledge.
- `dcache_inv_req_o`  out  1  invalidate request to D$.
- `dcache_inv_addr_o`  out  PLEN  address to D$.
- `dcache_inv_ack_i`  in  1  D$ acknowledge.
- `busy_o`  out  1  FIFO non-empty or FSM not IDLE.
- `inv_cnt_o`  out  CntWidth  completed invalidations, wraps at 2^CntWidth.

## Operation
- FIFO: `inv_gnt_o = !full`, combinational from the occupancy counter only; independent of `inv_req_i`. Push on `inv_req_i & inv_gnt_o`. No bypass: a pushed entry is visible at the head the following cycle. Occupancy counter width `$clog2(FifoDepth+1)`; read/write pointers wrap modulo FifoDepth.
- FSM states: IDLE, ISSUE, DONE.
  - IDLE: if FIFO non-empty → ISSUE. On entry to ISSUE, set `ic_pend = dc_pend = 1`.
  - ISSUE: `icache_inv_req_o = ic_pend`, `dcache_inv_req_o = dc_pend`. Both addresses are driven from the FIFO head. An ack with its pend flag set clears that flag. When no flag remains set after this cycle's acks → DONE. Acks can arrive in the same cycle or in either order.
  - DONE: `inv_done_o = 1`, `inv_done_addr_o` = head. Pop head, increment `inv_cnt_o`. Next state is ISSUE, with both pend flags set again, if the FIFO holds ≥1 entry after the pop; otherwise IDLE.
- An ack with its pend flag clear, or any ack outside ISSUE, is ignored. It must not alter state.
- Push and pop in the same cycle: occupancy is unchanged, and both pointers advance.
- Head address is stable for the whole ISSUE/DONE of an entry. Cache addresses are don't-care when the corresponding request is low, but must hold the head value.

## Timing
- Reset values: FSM IDLE; FIFO empty. `inv_gnt_o = 1`, `inv_done_o = 0`, both cache reqs 0, `busy_o = 0`, `inv_cnt_o = 0`. Address outputs are 0.
- All outputs are registered or decoded from registered state. No combinational path from ack inputs to request outputs.
- Minimum latency with an empty FIFO and acks asserted as soon as requests rise:
  - accept at cycle t,
  - IDLE sees the entry at t+1,
  - requests high at t+2, acks at t+2,
  - `inv_done_o` at t+3.
- Back-to-back throughput with immediate acks: one completion every 2 cycles (ISSUE, DONE).
- Requests drop in the cycle after the matching ack, and remain low until the next ISSUE entry.
- Reset mid-operation: asynchronous clear of all state, including pending FIFO entries. These entries are discarded, with no done pulse.

## Test plan
- Single invalidation: push 0x80001040 at t. Both acks at t+2 → both reqs high at t+2 with addr 0x80001040, low at t+3; `inv_done_o` at t+3 with same addr; `inv_cnt_o` = 1.
- Skewed acks: I$ ack 1 cycle after req rises, D$ ack 5 cycles after. `icache_inv_req_o` drops after 1 cycle while `dcache_inv_req_o` stays high. Done comes 1 cycle after the D$ ack, and there is exactly one done pulse.
- FIFO full: push 5 addresses consecutively with acks held low. `inv_gnt_o` drops after the 4th push, so the 5th is held off. After the first done, gnt returns to 1 and the 5th is accepted. Completions occur in push order.
- Spurious acks: assert both acks while IDLE, and repeat the D$ ack after its flag has cleared. State, `inv_cnt_o` and the done pulses are unaffected.
- Simultaneous push/pop: FIFO holds 2 entries, and a push occurs in the DONE cycle. Occupancy stays 2, and the next ISSUE starts the cycle after DONE.
- Reset mid-ISSUE: assert `rst_ni` low with 3 entries pending. All outputs go to their reset values immediately. After release, no requests are issued and `inv_cnt_o` = 0.
